// File: rtl/pipe_stage_reg_if.sv
// Single valid/ready link carrying LANES x WIDTH payload.
// master drives valid/data, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
);
  logic                         valid;
  logic                         ready;
  logic [LANES-1:0][WIDTH-1:0]  data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register, LANES x WIDTH.
// Optional second (skid) entry compiled in with `define PIPE_SKID_EN;
// without it the stage holds one entry and in_ready looks through out_ready.
// Emptied or flushed entries are zeroed so an empty stage shows all-zero data.

// One lane bit-slice: head entry plus skid entry, driven by shared controls.
module pipe_stage_lane #(
  parameter int WIDTH = 32
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             h_clr_i,
  input  logic             h_ld_in_i,
  input  logic             h_ld_skid_i,
  input  logic             s_clr_i,
  input  logic             s_ld_in_i,
  input  logic [WIDTH-1:0] in_d_i,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  // Next head/skid contents; refill from skid wins over new input.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (h_clr_i)          head_d = '0;
    else if (h_ld_skid_i) head_d = skid_q;
    else if (h_ld_in_i)   head_d = in_d_i;
    if (s_clr_i)          skid_d = '0;
    else if (s_ld_in_i)   skid_d = in_d_i;
  end

  // Entry storage, zeroed on reset.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign head_o = head_q;
endmodule

module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 flush_i,
  pipe_stage_reg_if.slave      up_if,
  pipe_stage_reg_if.master     dn_if,
  output logic [1:0]           occ_o
);
  typedef enum logic [1:0] {ST_EMPTY, ST_HEAD, ST_FULL} st_e;

  st_e  st_q, st_d;
  logic rdy_en_q;     // holds in_ready low until the first edge after reset
  logic head_vld;
  logic in_rdy;
  logic accept;
  logic release_w;
  logic h_clr, h_ld_in, h_ld_skid, s_clr, s_ld_in;

  assign head_vld = (st_q != ST_EMPTY);

`ifdef PIPE_SKID_EN
  logic skid_vld;
  assign skid_vld = (st_q == ST_FULL);
  // Registered occupancy only: no path from out_ready to in_ready.
  assign in_rdy   = rdy_en_q && !flush_i && !skid_vld;
`else
  assign in_rdy   = rdy_en_q && !flush_i && (!head_vld || dn_if.ready);
`endif

  assign accept    = up_if.valid && in_rdy;
  assign release_w = head_vld && dn_if.ready;

  // Ready-enable flag, low throughout reset.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end

  // Occupancy state register.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) st_q <= ST_EMPTY;
    else         st_q <= st_d;
  end

  // Next occupancy and entry load/clear controls; flush overrides everything.
  always_comb begin
    st_d      = st_q;
    h_clr     = 1'b0;
    h_ld_in   = 1'b0;
    h_ld_skid = 1'b0;
    s_clr     = 1'b0;
    s_ld_in   = 1'b0;
    if (flush_i) begin
      st_d  = ST_EMPTY;
      h_clr = 1'b1;
      s_clr = 1'b1;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          if (accept) begin
            h_ld_in = 1'b1;
            st_d    = ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (release_w && accept) begin
            h_ld_in = 1'b1;
          end else if (release_w) begin
            h_clr = 1'b1;
            st_d  = ST_EMPTY;
          end
`ifdef PIPE_SKID_EN
          else if (accept) begin
            s_ld_in = 1'b1;
            st_d    = ST_FULL;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        ST_FULL: begin
          // in_ready is low here, so only the skid->head move can happen.
          if (release_w) begin
            h_ld_skid = 1'b1;
            s_clr     = 1'b1;
            st_d      = ST_HEAD;
          end
        end
`endif
        default: st_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy count out of state.
  always_comb begin
    case (st_q)
      ST_HEAD: occ_o = 2'd1;
      ST_FULL: occ_o = 2'd2;
      default: occ_o = 2'd0;
    endcase
  end

  assign up_if.ready = in_rdy;
  assign dn_if.valid = head_vld;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pipe_stage_lane #(.WIDTH(WIDTH)) u_lane (
      .gclk        (gclk),
      .grst_n      (grst_n),
      .h_clr_i     (h_clr),
      .h_ld_in_i   (h_ld_in),
      .h_ld_skid_i (h_ld_skid),
      .s_clr_i     (s_clr),
      .s_ld_in_i   (s_ld_in),
      .in_d_i      (up_if.data[k]),
      .head_o      (dn_if.data[k])
    );
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: reset, directed table, streaming, async reset
// mid-stream, then random traffic against a queue model of the stage.
module tb_pipe_stage_reg;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int DW = W * L;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       gclk = 1'b0;
  logic       grst_n;
  logic       flush;
  logic [1:0] occ;

  pipe_stage_reg_if #(.WIDTH(W), .LANES(L)) up_if ();
  pipe_stage_reg_if #(.WIDTH(W), .LANES(L)) dn_if ();

  pipe_stage_reg #(.WIDTH(W), .LANES(L)) dut (
    .gclk    (gclk),
    .grst_n  (grst_n),
    .flush_i (flush),
    .up_if   (up_if),
    .dn_if   (dn_if),
    .occ_o   (occ)
  );

  always #5 gclk = ~gclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Beat n: lane k = 0x1000_0000*k + n; negative n means the all-zero word.
  function automatic logic [DW-1:0] mk(input int n);
    logic [DW-1:0] r;
    r = '0;
    if (n >= 0)
      for (int k = 0; k < L; k++) r[k*W +: W] = W'(64'h1000_0000 * k + 64'(n));
    return r;
  endfunction

  typedef struct {
    bit fl;
    bit v;
    int n;
    bit ordy;
    bit e_v;
    bit e_r;
    int e_occ;
    int e_n;
  } vec_t;

  vec_t vt[14];

  task automatic drive(input bit fl, input bit v, input logic [DW-1:0] d, input bit ordy);
    flush       = fl;
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = ordy;
  endtask

  logic [DW-1:0] q[$];

  initial begin
    logic [DW-1:0] rd;
    bit            fl, v, ordy, er, acc;
    int            beats, cyc;

    grst_n = 1'b0;
    drive(0, 0, '0, 0);

    // ---------------- reset state ----------------
    #1;
    chk("rst_valid", DW'(dn_if.valid), '0);
    chk("rst_data",  dn_if.data, '0);
    chk("rst_occ",   DW'(occ), '0);
    chk("rst_ready", DW'(up_if.ready), '0);
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    grst_n = 1'b1;
    #1;
    chk("rst_ready_pre_edge", DW'(up_if.ready), '0);
    @(posedge gclk);
    @(negedge gclk);
    #1;
    chk("rst_ready_post_edge", DW'(up_if.ready), DW'(1));

    // ---------------- directed table ----------------
    //         fl v  n       ordy e_v e_r     e_occ          e_n
    vt[0]  = '{0, 1, 'hA,    1,   0,  1,      0,             -1};
    vt[1]  = '{0, 1, 'hB,    0,   1,  SKID,   1,             'hA};
    vt[2]  = '{0, 1, 'hB,    0,   1,  0,      SKID ? 2 : 1,  'hA};
    vt[3]  = '{0, 1, 'hB,    0,   1,  0,      SKID ? 2 : 1,  'hA};
    vt[4]  = '{0, 1, 'hB,    1,   1,  !SKID,  SKID ? 2 : 1,  'hA};
    vt[5]  = '{0, 0, 0,      1,   1,  1,      1,             'hB};
    vt[6]  = '{0, 0, 0,      1,   0,  1,      0,             -1};
    vt[7]  = '{0, 1, 1,      0,   0,  1,      0,             -1};
    vt[8]  = '{0, 1, 2,      0,   1,  SKID,   1,             1};
    vt[9]  = '{1, 1, 'hDEAD, 0,   1,  0,      SKID ? 2 : 1,  1};
    vt[10] = '{0, 0, 0,      1,   0,  1,      0,             -1};
    vt[11] = '{0, 1, 3,      1,   0,  1,      0,             -1};
    vt[12] = '{0, 0, 0,      1,   1,  1,      1,             3};
    vt[13] = '{0, 0, 0,      1,   0,  1,      0,             -1};
    for (int i = 0; i < 14; i++) begin
      @(negedge gclk);
      drive(vt[i].fl, vt[i].v, mk(vt[i].n), vt[i].ordy);
      #1;
      chk($sformatf("tbl%0d_valid", i), DW'(dn_if.valid), DW'(vt[i].e_v));
      chk($sformatf("tbl%0d_ready", i), DW'(up_if.ready), DW'(vt[i].e_r));
      chk($sformatf("tbl%0d_occ", i),   DW'(occ),         DW'(vt[i].e_occ));
      chk($sformatf("tbl%0d_data", i),  dn_if.data,       mk(vt[i].e_n));
    end

    // ---------------- streaming: 16 beats back to back ----------------
    for (int n = 0; n <= 16; n++) begin
      @(negedge gclk);
      drive(0, n < 16, mk(n < 16 ? n : 0), 1);
      #1;
      chk($sformatf("strm%0d_ready", n), DW'(up_if.ready), DW'(1));
      chk($sformatf("strm%0d_valid", n), DW'(dn_if.valid), DW'(n > 0));
      chk($sformatf("strm%0d_data", n),  dn_if.data, mk(n > 0 ? n - 1 : -1));
    end
    @(negedge gclk);
    drive(0, 0, '0, 1);
    #1;
    chk("strm_drained", DW'(dn_if.valid), '0);

    // ---------------- async reset with a beat held ----------------
    drive(0, 1, mk('h55), 0);
    @(posedge gclk);
    @(negedge gclk);
    drive(0, 0, '0, 0);
    #1;
    chk("mid_occ_before", DW'(occ), DW'(1));
    #2;
    grst_n = 1'b0;
    #1;
    chk("mid_rst_valid", DW'(dn_if.valid), '0);
    chk("mid_rst_data",  dn_if.data, '0);
    chk("mid_rst_occ",   DW'(occ), '0);
    chk("mid_rst_ready", DW'(up_if.ready), '0);
    @(negedge gclk);
    grst_n = 1'b1;
    @(posedge gclk);

    // ---------------- random traffic vs queue model ----------------
    q.delete();
    beats = 0;
    cyc   = 0;
    while (beats < 10000 && cyc < 80000) begin
      @(negedge gclk);
      fl   = ($urandom_range(0, 31) == 0);
      v    = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 1) == 1;
      for (int k = 0; k < L; k++) rd[k*W +: W] = W'($urandom);
      drive(fl, v, rd, ordy);
      #1;
      if (SKID) er = !fl && (q.size() < 2);
      else      er = !fl && (q.size() == 0 || ordy);
      acc = v && er;
      chk("rnd_ready", DW'(up_if.ready), DW'(er));
      chk("rnd_valid", DW'(dn_if.valid), DW'(q.size() > 0));
      chk("rnd_occ",   DW'(occ),         DW'(q.size()));
      chk("rnd_data",  dn_if.data,       q.size() > 0 ? q[0] : '0);
      @(posedge gclk);
      if (fl) q.delete();
      else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) begin
          q.push_back(rd);
          beats++;
        end
      end
      cyc++;
    end
    checks++;
    if (beats < 10000) begin
      errors++;
      $display("FAIL rnd_budget: got %0d beats expected 10000 within 80000 cycles", beats);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
